// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared types for the enemy spawn scheduler: FSM state, enemy counter width and spawn-point index.
package battle_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, REQUEST, DONE} spawn_state_t;

  localparam int ENEMY_CNT_W = 6;

  typedef logic [1:0] spawn_pt_t;

  // Rotating spawn-point successor, wrapping at the number of configured points.
  function automatic spawn_pt_t next_pt(input spawn_pt_t p, input int num_pts);
    if (int'(p) + 1 >= num_pts) return '0;
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Spawn request bus between the scheduler (master) and the tank/sprite datapath (slave).
interface enemy_spawn_scheduler_if #(
  parameter int SLOT_W = 2
) ();

  // Valid/ready: spawn_valid stays high with slot and point frozen until a cycle where
  // spawn_ready is also high; that cycle is the grant, and valid never drops before it.
  logic                  spawn_valid;
  logic                  spawn_ready;
  logic [SLOT_W-1:0]     spawn_slot;
  battle_pkg::spawn_pt_t spawn_point;

  modport master (
    output spawn_valid,
    output spawn_slot,
    output spawn_point,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_slot,
    input  spawn_point,
    output spawn_ready
  );

endinterface

// File: rtl/enemy_spawn_scheduler_free_slot_finder.sv
// Lowest-index clear-bit priority encoder over the active slot mask.
module free_slot_finder #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan downward so the lowest clear bit is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        found = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn sequencer: reserve/slot bookkeeping, delayed valid/ready spawn requests, kill counting.
// Optional macro SPAWN_BLOCK_EN adds spawn_blocked and skips occupied spawn points.
module enemy_spawn_scheduler
  import battle_pkg::*;
#(
  parameter  int MAX_ACTIVE    = 4,
  parameter  int TOTAL_ENEMIES = 20,
  parameter  int SPAWN_DELAY   = 60,
  parameter  int NUM_SPAWN_PTS = 3,
  localparam int SLOT_W        = $clog2(MAX_ACTIVE),
  localparam int CNT_W         = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   run,
  input  logic                   kill,
  input  logic [SLOT_W-1:0]      kill_slot,
`ifdef SPAWN_BLOCK_EN
  input  logic [NUM_SPAWN_PTS-1:0] spawn_blocked,
`endif
  enemy_spawn_scheduler_if.master spawn_if,
  output logic [MAX_ACTIVE-1:0]  active_mask,
  output logic [ENEMY_CNT_W-1:0] enemies_left,
  output logic                   all_cleared,
  output spawn_state_t           dbg_state
);

  localparam logic [CNT_W-1:0]       CNT_MAX   = CNT_W'(SPAWN_DELAY - 1);
  localparam logic [ENEMY_CNT_W-1:0] ENEMY_TOT = ENEMY_CNT_W'(TOTAL_ENEMIES);

  spawn_state_t           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ENEMY_CNT_W-1:0] reserve_q, reserve_d;
  logic [ENEMY_CNT_W-1:0] enemies_left_q, enemies_left_d;
  logic [MAX_ACTIVE-1:0]  active_mask_q, active_mask_d;
  spawn_pt_t              pt_idx_q, pt_idx_d;
  logic [SLOT_W-1:0]      spawn_slot_q, spawn_slot_d;
  spawn_pt_t              spawn_point_q, spawn_point_d;

  logic              free_found;
  logic [SLOT_W-1:0] free_idx;
  logic              sel_found;
  spawn_pt_t         sel_pt;
  logic              grant, kill_hit, can_req;

  free_slot_finder #(.N(MAX_ACTIVE)) u_free_slot_finder (
    .mask  (active_mask_q),
    .found (free_found),
    .index (free_idx)
  );

`ifdef SPAWN_BLOCK_EN
  // First unblocked point at or after the rotating index, with wraparound.
  always_comb begin
    sel_found = 1'b0;
    sel_pt    = pt_idx_q;
    for (int k = NUM_SPAWN_PTS - 1; k >= 0; k--) begin
      if (!spawn_blocked[(int'(pt_idx_q) + k) % NUM_SPAWN_PTS]) begin
        sel_found = 1'b1;
        sel_pt    = spawn_pt_t'((int'(pt_idx_q) + k) % NUM_SPAWN_PTS);
      end
    end
  end
`else
  assign sel_found = 1'b1;
  assign sel_pt    = pt_idx_q;
`endif

  assign grant    = (state_q == REQUEST) && spawn_if.spawn_ready;
  assign kill_hit = kill && ((state_q == WAIT) || (state_q == REQUEST)) &&
                    active_mask_q[kill_slot];
  assign can_req  = (state_q == WAIT) && run && (cnt_q == CNT_MAX) &&
                    (reserve_q != '0) && free_found && sel_found;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      reserve_q      <= '0;
      enemies_left_q <= '0;
      active_mask_q  <= '0;
      pt_idx_q       <= '0;
      spawn_slot_q   <= '0;
      spawn_point_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      reserve_q      <= reserve_d;
      enemies_left_q <= enemies_left_d;
      active_mask_q  <= active_mask_d;
      pt_idx_q       <= pt_idx_d;
      spawn_slot_q   <= spawn_slot_d;
      spawn_point_q  <= spawn_point_d;
    end
  end

  // A kill only ever hits an occupied slot, so the count cannot already be zero.
  always_ff @(posedge frame_clk) begin
    if (!Reset && !start && kill_hit) begin
      assert (enemies_left_q != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          if (enemies_left_d == '0) state_d = DONE;
          else if (can_req)         state_d = REQUEST;
        end
        REQUEST: begin
          if (enemies_left_d == '0) state_d = DONE;
          else if (grant)           state_d = WAIT;
        end
        IDLE, DONE: state_d = state_q;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d          = cnt_q;
    reserve_d      = reserve_q;
    enemies_left_d = enemies_left_q;
    active_mask_d  = active_mask_q;
    pt_idx_d       = pt_idx_q;
    spawn_slot_d   = spawn_slot_q;
    spawn_point_d  = spawn_point_q;
    if (start) begin
      cnt_d          = '0;
      reserve_d      = ENEMY_TOT;
      enemies_left_d = ENEMY_TOT;
      active_mask_d  = '0;
      pt_idx_d       = '0;
      spawn_slot_d   = '0;
      spawn_point_d  = '0;
    end else begin
      if ((state_q == WAIT) && run && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
      if (can_req) begin
        spawn_slot_d  = free_idx;
        spawn_point_d = sel_pt;
      end
      // Grant and kill never target the same slot: the grant slot was clear when chosen.
      if (grant) begin
        active_mask_d[spawn_slot_q] = 1'b1;
        reserve_d                   = reserve_q - 1'b1;
        pt_idx_d                    = next_pt(spawn_point_q, NUM_SPAWN_PTS);
        cnt_d                       = '0;
      end
      if (kill_hit) begin
        active_mask_d[kill_slot] = 1'b0;
        enemies_left_d           = enemies_left_q - 1'b1;
      end
    end
  end

  always_comb begin
    spawn_if.spawn_valid = (state_q == REQUEST);
    spawn_if.spawn_slot  = spawn_slot_q;
    spawn_if.spawn_point = spawn_point_q;
    active_mask          = active_mask_q;
    enemies_left         = enemies_left_q;
    all_cleared          = (state_q == DONE);
    dbg_state            = state_q;
  end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler with default parameters (4 slots, 20 enemies, delay 60, 3 points).
module tb_enemy_spawn_scheduler;
  import battle_pkg::*;

  logic         frame_clk;
  logic         Reset, start, run, kill;
  logic [1:0]   kill_slot;
  logic [3:0]   active_mask;
  logic [5:0]   enemies_left;
  logic         all_cleared;
  spawn_state_t dbg_state;
`ifdef SPAWN_BLOCK_EN
  logic [2:0]   spawn_blocked;
`endif

  int n_pass;
  int n_total;

  enemy_spawn_scheduler_if #(.SLOT_W(2)) sif ();

  enemy_spawn_scheduler dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .start         (start),
    .run           (run),
    .kill          (kill),
    .kill_slot     (kill_slot),
`ifdef SPAWN_BLOCK_EN
    .spawn_blocked (spawn_blocked),
`endif
    .spawn_if      (sif),
    .active_mask   (active_mask),
    .enemies_left  (enemies_left),
    .all_cleared   (all_cleared),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!sif.spawn_valid && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_next(input int max_cyc, output int n);
    n = 0;
    tick();
    n++;
    while (!sif.spawn_valid && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; run = 1'b1; kill = 1'b0; kill_slot = 2'd0;
    sif.spawn_ready = 1'b1;
`ifdef SPAWN_BLOCK_EN
    spawn_blocked = 3'b000;
`endif
    tick();
    tick();
    Reset = 1'b0;
    n_total++;
    if (sif.spawn_valid !== 1'b0 || sif.spawn_slot !== 2'd0 || sif.spawn_point !== 2'd0 ||
        active_mask !== 4'h0 || enemies_left !== 6'd0 || all_cleared !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL reset_values: valid=%b slot=%0d pt=%0d mask=%h left=%0d clr=%b st=%0d required all zero/IDLE",
               sif.spawn_valid, sif.spawn_slot, sif.spawn_point, active_mask, enemies_left, all_cleared, dbg_state);
    else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (dbg_state !== IDLE || sif.spawn_valid !== 1'b0)
      $display("FAIL idle_hold: st=%0d valid=%b required IDLE/0", dbg_state, sif.spawn_valid);
    else n_pass++;
  endtask

  task automatic test_first_spawns();
    logic [1:0] exp_q[$];
    logic [1:0] exp_pt_q[$];
    logic [1:0] es, ep;
    int n;
    exp_q    = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_pt_q = '{2'd0, 2'd1, 2'd2, 2'd0};
    run = 1'b1; sif.spawn_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (dbg_state !== WAIT || enemies_left !== 6'd20 || sif.spawn_valid !== 1'b0)
      $display("FAIL start_load: st=%0d left=%0d valid=%b required WAIT/20/0", dbg_state, enemies_left, sif.spawn_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) wait_valid(200, n);
      else        wait_next(200, n);
      es = exp_q.pop_front();
      ep = exp_pt_q.pop_front();
      n_total++;
      if (n !== ((i == 0) ? 60 : 61))
        $display("FAIL spawn_latency_%0d: got %0d cycles required %0d", i, n, (i == 0) ? 60 : 61);
      else n_pass++;
      n_total++;
      if (sif.spawn_slot !== es || sif.spawn_point !== ep)
        $display("FAIL spawn_target_%0d: slot=%0d pt=%0d required slot=%0d pt=%0d", i, sif.spawn_slot, sif.spawn_point, es, ep);
      else n_pass++;
    end
    tick();
    n_total++;
    if (active_mask !== 4'hF || sif.spawn_valid !== 1'b0 || enemies_left !== 6'd20)
      $display("FAIL fill_all: mask=%h valid=%b left=%0d required F/0/20", active_mask, sif.spawn_valid, enemies_left);
    else n_pass++;
  endtask

  task automatic test_full_block();
    int seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sif.spawn_valid) seen++;
    end
    n_total++;
    if (seen !== 0 || dbg_state !== WAIT)
      $display("FAIL full_no_request: valid cycles=%0d st=%0d required 0/WAIT", seen, dbg_state);
    else n_pass++;
    kill = 1'b1; kill_slot = 2'd2;
    tick();
    kill = 1'b0;
    n_total++;
    if (enemies_left !== 6'd19 || active_mask !== 4'hB || sif.spawn_valid !== 1'b0)
      $display("FAIL kill_slot2: left=%0d mask=%h valid=%b required 19/B/0", enemies_left, active_mask, sif.spawn_valid);
    else n_pass++;
    tick();
    n_total++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_slot !== 2'd2 || sif.spawn_point !== 2'd1)
      $display("FAIL refill_request: valid=%b slot=%0d pt=%0d required 1/2/1", sif.spawn_valid, sif.spawn_slot, sif.spawn_point);
    else n_pass++;
    sif.spawn_ready = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      run = i[0];
      tick();
      n_total++;
      if (sif.spawn_valid !== 1'b1 || sif.spawn_slot !== 2'd2 || sif.spawn_point !== 2'd1 || active_mask !== 4'hB)
        $display("FAIL stall_hold_%0d: valid=%b slot=%0d pt=%0d mask=%h required 1/2/1/B",
                 i, sif.spawn_valid, sif.spawn_slot, sif.spawn_point, active_mask);
      else n_pass++;
    end
    run = 1'b1;
    sif.spawn_ready = 1'b1;
    tick();
    n_total++;
    if (sif.spawn_valid !== 1'b0 || active_mask !== 4'hF || dbg_state !== WAIT)
      $display("FAIL stall_grant: valid=%b mask=%h st=%0d required 0/F/WAIT", sif.spawn_valid, active_mask, dbg_state);
    else n_pass++;
  endtask

  task automatic test_kill_cases();
    int n;
    sif.spawn_ready = 1'b0;
    kill = 1'b1; kill_slot = 2'd0;
    tick();
    kill = 1'b0;
    n_total++;
    if (enemies_left !== 6'd18 || active_mask !== 4'hE)
      $display("FAIL kill_slot0: left=%0d mask=%h required 18/E", enemies_left, active_mask);
    else n_pass++;
    kill = 1'b1; kill_slot = 2'd0;
    tick();
    kill = 1'b0;
    n_total++;
    if (enemies_left !== 6'd18 || active_mask !== 4'hE)
      $display("FAIL kill_empty: left=%0d mask=%h required 18/E", enemies_left, active_mask);
    else n_pass++;
    wait_valid(200, n);
    n_total++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_slot !== 2'd0 || sif.spawn_point !== 2'd2)
      $display("FAIL slot0_request: valid=%b slot=%0d pt=%0d required 1/0/2", sif.spawn_valid, sif.spawn_slot, sif.spawn_point);
    else n_pass++;
    sif.spawn_ready = 1'b1;
    kill = 1'b1; kill_slot = 2'd1;
    tick();
    kill = 1'b0;
    n_total++;
    if (active_mask !== 4'hD || enemies_left !== 6'd17 || sif.spawn_valid !== 1'b0)
      $display("FAIL kill_with_grant: mask=%h left=%0d valid=%b required D/17/0", active_mask, enemies_left, sif.spawn_valid);
    else n_pass++;
  endtask

  task automatic test_clear();
    int kills, grants;
    kills = 0; grants = 0;
    sif.spawn_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (enemies_left == 6'd0) break;
      if (sif.spawn_valid) grants++;
      if (active_mask != 4'h0) begin
        kill = 1'b1;
        kill_slot = active_mask[0] ? 2'd0 : active_mask[1] ? 2'd1 : active_mask[2] ? 2'd2 : 2'd3;
        kills++;
      end
      tick();
      kill = 1'b0;
    end
    n_total++;
    if (enemies_left !== 6'd0 || all_cleared !== 1'b1 || dbg_state !== DONE || active_mask !== 4'h0 || sif.spawn_valid !== 1'b0)
      $display("FAIL cleared: left=%0d clr=%b st=%0d mask=%h valid=%b required 0/1/DONE/0/0",
               enemies_left, all_cleared, dbg_state, active_mask, sif.spawn_valid);
    else n_pass++;
    n_total++;
    if (kills !== 17 || grants !== 14)
      $display("FAIL clear_counts: kills=%0d grants=%0d required 17/14", kills, grants);
    else n_pass++;
    kill = 1'b1; kill_slot = 2'd0;
    tick();
    kill = 1'b0;
    n_total++;
    if (enemies_left !== 6'd0 || dbg_state !== DONE || all_cleared !== 1'b1)
      $display("FAIL kill_in_done: left=%0d st=%0d clr=%b required 0/DONE/1", enemies_left, dbg_state, all_cleared);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (all_cleared !== 1'b0 || enemies_left !== 6'd20 || dbg_state !== WAIT || active_mask !== 4'h0)
      $display("FAIL restart: clr=%b left=%0d st=%0d mask=%h required 0/20/WAIT/0", all_cleared, enemies_left, dbg_state, active_mask);
    else n_pass++;
  endtask

  task automatic test_reset_mid_request();
    int n;
    sif.spawn_ready = 1'b1;
    wait_valid(200, n);
    tick();
    sif.spawn_ready = 1'b0;
    wait_valid(200, n);
    n_total++;
    if (sif.spawn_valid !== 1'b1 || sif.spawn_slot !== 2'd1 || sif.spawn_point !== 2'd1)
      $display("FAIL pre_reset_request: valid=%b slot=%0d pt=%0d required 1/1/1", sif.spawn_valid, sif.spawn_slot, sif.spawn_point);
    else n_pass++;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_total++;
    if (sif.spawn_valid !== 1'b0 || sif.spawn_slot !== 2'd0 || sif.spawn_point !== 2'd0 ||
        active_mask !== 4'h0 || enemies_left !== 6'd0 || all_cleared !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL mid_request_reset: valid=%b slot=%0d pt=%0d mask=%h left=%0d clr=%b st=%0d required zero/IDLE",
               sif.spawn_valid, sif.spawn_slot, sif.spawn_point, active_mask, enemies_left, all_cleared, dbg_state);
    else n_pass++;
    tick();
    n_total++;
    if (dbg_state !== IDLE || sif.spawn_valid !== 1'b0)
      $display("FAIL post_reset_idle: st=%0d valid=%b required IDLE/0", dbg_state, sif.spawn_valid);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_first_spawns();
    test_full_block();
    test_stall();
    test_kill_cases();
    test_clear();
    test_reset_mid_request();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
